max_exp_collect: RTL and testbench

MAX_EXP_COLLECT -- requirements
Module: max_exp_collect

---
 rtl/max_exp_collect.sv | 131 +++++++++++++
 tb/tb_max_exp_collect.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/max_exp_collect.sv
// max_exp_collect
//   Gathers up to DEPTH denormalized partial products into a group and tracks
//   the group's maximum exponent. Once the group closes (early via i_last, or
//   when the buffer fills), it replays every entry in arrival order alongside
//   that maximum so the align stage can shift each operand against a single
//   reference exponent.
//
// Ports
//   i_clk, i_rst           clock; asynchronous active-high reset
//   i_valid / o_ready      upstream handshake for one (pp, exp) entry
//   i_pp[3:0]              partial product: bit 3 sign, bits 2:0 magnitude
//   i_exp[5:0]             unsigned exponent of i_pp
//   i_last                 entry closes the group early
//   o_valid / i_ready      downstream handshake for one operand triple
//   o_pp, o_exp            buffered entry, returned bit-identical
//   o_max_exp              group maximum exponent, held for the whole group
//   o_last                 marks the final triple of the group
module max_exp_collect #(
    parameter int DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [3:0] i_pp,
    input  logic [5:0] i_exp,
    input  logic       i_last,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [3:0] o_pp,
    output logic [5:0] o_exp,
    output logic [5:0] o_max_exp,
    output logic       o_last
);

    localparam int CW = $clog2(DEPTH);

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;      // next free slot while collecting
    logic [CW-1:0] rd;       // slot currently presented while emitting
    logic [CW-1:0] size_m1;  // group size minus one, latched at close
    logic [5:0]    run_max;

    logic [3:0] pp_mem  [DEPTH];
    logic [5:0] exp_mem [DEPTH];

    logic          accept;
    logic          close;
    logic [5:0]    max_nxt;
    logic [CW-1:0] rd_nxt;

    // o_ready is a register that is only ever 1 in COLLECT, so acceptance
    // implies the COLLECT state without decoding it again.
    assign accept  = i_valid && o_ready;
    assign close   = accept && (i_last || (cnt == CW'(DEPTH - 1)));
    // Zero-magnitude entries carry no information about alignment, so they
    // never raise the maximum.
    assign max_nxt = (accept && (|i_pp[2:0]) && (i_exp > run_max)) ? i_exp : run_max;
    assign rd_nxt  = rd + 1'b1;

    // Entry storage: no reset, contents are only ever read after being written.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            pp_mem[cnt]  <= i_pp;
            exp_mem[cnt] <= i_exp;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= COLLECT;
            cnt       <= '0;
            rd        <= '0;
            size_m1   <= '0;
            run_max   <= '0;
            o_ready   <= 1'b0;
            o_valid   <= 1'b0;
            o_pp      <= '0;
            o_exp     <= '0;
            o_max_exp <= '0;
            o_last    <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    o_ready <= 1'b1;
                    if (accept) begin
                        cnt     <= cnt + 1'b1;
                        run_max <= max_nxt;
                    end
                    if (close) begin
                        // Preload slot 0 so the first triple appears one cycle
                        // after the closing acceptance. A one-entry group has
                        // slot 0 being written this very edge, so bypass it.
                        state     <= EMIT;
                        o_ready   <= 1'b0;
                        o_valid   <= 1'b1;
                        cnt       <= '0;
                        rd        <= '0;
                        size_m1   <= cnt;
                        o_max_exp <= max_nxt;
                        o_pp      <= (cnt == '0) ? i_pp  : pp_mem[0];
                        o_exp     <= (cnt == '0) ? i_exp : exp_mem[0];
                        o_last    <= (cnt == '0);
                    end
                end
                EMIT: begin
                    if (i_ready) begin
                        if (o_last) begin
                            state   <= COLLECT;
                            o_valid <= 1'b0;
                            o_ready <= 1'b1;
                            o_last  <= 1'b0;
                            rd      <= '0;
                            cnt     <= '0;
                            run_max <= '0;
                        end else begin
                            rd     <= rd_nxt;
                            o_pp   <= pp_mem[rd_nxt];
                            o_exp  <= exp_mem[rd_nxt];
                            o_last <= (rd_nxt == size_m1);
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_max_exp_collect.sv
module tb_max_exp_collect;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] i_pp;
    logic [5:0] i_exp;
    logic       i_last;
    logic       o_valid;
    logic       i_ready;
    logic [3:0] o_pp;
    logic [5:0] o_exp;
    logic [5:0] o_max_exp;
    logic       o_last;

    int checks = 0;
    int errors = 0;

    max_exp_collect #(.DEPTH(8)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_pp      (i_pp),
        .i_exp     (i_exp),
        .i_last    (i_last),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_pp      (o_pp),
        .o_exp     (o_exp),
        .o_max_exp (o_max_exp),
        .o_last    (o_last)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Offer one entry; block must be ready and not presenting.
    task automatic send(input string tag, input logic [3:0] pp, input logic [5:0] e, input logic last);
        @(negedge i_clk);
        chk(tag, {30'd0, o_ready, o_valid}, 32'b10);
        i_valid = 1'b1;
        i_pp    = pp;
        i_exp   = e;
        i_last  = last;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
    endtask

    // Idle cycle with junk on the data lines, which must be ignored.
    task automatic gap();
        @(negedge i_clk);
        i_valid = 1'b0;
        i_pp    = 4'b0111;
        i_exp   = 6'd62;
        i_last  = 1'b1;
        @(posedge i_clk);
    endtask

    // Check the presented triple, then drive i_ready for one edge.
    task automatic rx(input string tag, input logic [3:0] pp, input logic [5:0] e,
                      input logic [5:0] mx, input logic last, input logic rdy);
        @(negedge i_clk);
        chk(tag, {14'd0, o_valid, o_pp, o_exp, o_max_exp, o_last},
                 {14'd0, 1'b1, pp, e, mx, last});
        i_ready = rdy;
        @(posedge i_clk);
        #1 i_ready = 1'b0;
    endtask

    // After the final emit the block is back to collecting at once.
    task automatic idle_chk(input string tag);
        @(negedge i_clk);
        chk(tag, {29'd0, o_ready, o_valid, o_last}, 32'b100);
    endtask

    initial begin
        logic [5:0] fexp [8];
        logic [5:0] gexp [8];
        logic [3:0] gpp  [8];
        fexp = '{6'd3, 6'd9, 6'd1, 6'd12, 6'd12, 6'd0, 6'd7, 6'd5};
        gexp = '{6'd7, 6'd2, 6'd33, 6'd1, 6'd63, 6'd0, 6'd8, 6'd9};
        gpp  = '{4'b0001, 4'b1010, 4'b0011, 4'b1111, 4'b1000, 4'b0100, 4'b1110, 4'b0101};

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_pp = '0; i_exp = '0; i_last = 1'b0;

        // Reset state
        @(negedge i_clk);
        chk("reset_outputs", {14'd0, o_ready, o_valid, o_pp, o_exp, o_max_exp, o_last}, 32'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1 chk("ready_low_until_edge", {31'd0, o_ready}, 32'd0);

        // Full group of 8, max 12, last only on the 8th
        for (int i = 0; i < 8; i++) send("full_send", 4'b0100, fexp[i], 1'b0);
        for (int i = 0; i < 8; i++) rx("full_emit", 4'b0100, fexp[i], 6'd12, i == 7, 1'b1);
        idle_chk("full_ready_after");

        // Early close on the 3rd entry
        send("early_send", 4'b0001, 6'd4, 1'b0);
        send("early_send", 4'b1010, 6'd6, 1'b0);
        send("early_send", 4'b0111, 6'd2, 1'b1);
        rx("early_emit0", 4'b0001, 6'd4, 6'd6, 1'b0, 1'b1);
        rx("early_emit1", 4'b1010, 6'd6, 6'd6, 1'b0, 1'b1);
        rx("early_emit2", 4'b0111, 6'd2, 6'd6, 1'b1, 1'b1);
        idle_chk("early_ready_after");

        // Zero-magnitude entry does not set the max
        send("zero_send", 4'b0000, 6'd40, 1'b0);
        send("zero_send", 4'b1101, 6'd5, 1'b1);
        rx("zero_emit0", 4'b0000, 6'd40, 6'd5, 1'b0, 1'b1);
        rx("zero_emit1", 4'b1101, 6'd5, 6'd5, 1'b1, 1'b1);
        idle_chk("zero_ready_after");

        // Backpressure 1,0,0,1 then drain
        send("bp_send", 4'b0010, 6'd10, 1'b0);
        send("bp_send", 4'b0011, 6'd20, 1'b0);
        send("bp_send", 4'b0100, 6'd30, 1'b1);
        rx("bp_emit0",      4'b0010, 6'd10, 6'd30, 1'b0, 1'b1);
        rx("bp_emit1_stall", 4'b0011, 6'd20, 6'd30, 1'b0, 1'b0);
        rx("bp_emit1_hold",  4'b0011, 6'd20, 6'd30, 1'b0, 1'b0);
        rx("bp_emit1_go",    4'b0011, 6'd20, 6'd30, 1'b0, 1'b1);
        rx("bp_emit2",       4'b0100, 6'd30, 6'd30, 1'b1, 1'b1);
        idle_chk("bp_ready_after");

        // Reset mid-EMIT after 2 of 5 emits
        for (int i = 0; i < 5; i++) send("rst_send", 4'b0001, 6'(50 + i), i == 4);
        rx("rst_emit0", 4'b0001, 6'd50, 6'd54, 1'b0, 1'b1);
        rx("rst_emit1", 4'b0001, 6'd51, 6'd54, 1'b0, 1'b1);
        @(negedge i_clk);
        i_rst = 1'b1;
        #1 chk("rst_async_clear", {14'd0, o_ready, o_valid, o_pp, o_exp, o_max_exp, o_last}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        send("post_rst_send", 4'b0110, 6'd3, 1'b0);
        send("post_rst_send", 4'b0101, 6'd1, 1'b1);
        rx("post_rst_emit0", 4'b0110, 6'd3, 6'd3, 1'b0, 1'b1);
        rx("post_rst_emit1", 4'b0101, 6'd1, 6'd3, 1'b1, 1'b1);
        idle_chk("post_rst_ready_after");

        // Gapped input, i_last coincides with the 8th entry; 63 has zero magnitude
        for (int i = 0; i < 8; i++) begin
            send("gap_send", gpp[i], gexp[i], i == 7);
            if (i != 7) gap();
        end
        for (int i = 0; i < 8; i++) rx("gap_emit", gpp[i], gexp[i], 6'd33, i == 7, 1'b1);
        idle_chk("gap_ready_after");
        i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        idle_chk("gap_single_group");
        i_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
